// File: rtl/atomsyn_pkg.sv
// rtl/atomsyn_pkg.sv - shared types, addresses and ctrl-word layout for the atom config path
package atomsyn_pkg;

    typedef logic [31:0] int32_t;
    typedef logic        bool;
    typedef logic [1:0]  int2_t;

    localparam logic [2:0] CFG_ADDR_CTRL  = 3'd0;
    localparam logic [2:0] CFG_ADDR_CONS1 = 3'd1;
    localparam logic [2:0] CFG_ADDR_CONS2 = 3'd2;
    localparam logic [2:0] CFG_ADDR_CONS3 = 3'd3;

    // Low bit position of each field inside the ctrl word
    localparam int CTRL_SEL_1  = 0;
    localparam int CTRL_SEL_2  = 1;
    localparam int CTRL_SEL_3  = 3;
    localparam int CTRL_SEL_4  = 4;
    localparam int CTRL_SEL_5  = 6;
    localparam int CTRL_SEL_6  = 7;
    localparam int CTRL_REL_OP = 9;
    localparam int CTRL_W      = 11;

    typedef struct packed {
        bool    sel_1;
        int2_t  sel_2;
        bool    sel_3;
        int2_t  sel_4;
        bool    sel_5;
        int2_t  sel_6;
        int2_t  rel_opcode;
        int32_t cons_1;
        int32_t cons_2;
        int32_t cons_3;
    } atom_cfg_t;

endpackage

// File: rtl/atom_cfg_loader_if.sv
// rtl/atom_cfg_loader_if.sv - software-facing shadow write and commit handshake bundle
interface atom_cfg_loader_if #(
    parameter int GEN_W = 8
) ();
    import atomsyn_pkg::*;

    logic             cfg_wr_valid;
    logic             cfg_wr_ready;
    logic [2:0]       cfg_wr_addr;
    int32_t           cfg_wr_data;
    logic             cfg_wr_err;
    logic             cfg_commit_req;
    logic             cfg_commit_ack;
    logic             cfg_commit_err;
    logic [GEN_W-1:0] cfg_gen;

    modport master (
        output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit_req,
        input  cfg_wr_ready, cfg_wr_err, cfg_commit_ack, cfg_commit_err, cfg_gen
    );

    modport slave (
        input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit_req,
        output cfg_wr_ready, cfg_wr_err, cfg_commit_ack, cfg_commit_err, cfg_gen
    );

endinterface

// File: rtl/atom_cfg_loader_decode.sv
// rtl/atom_cfg_loader_decode.sv - merges one shadow write into the current shadow bank
module atom_cfg_decode
    import atomsyn_pkg::*;
(
    input  logic [2:0] wr_addr,
    input  int32_t     wr_data,
    input  atom_cfg_t  cur_cfg,
    output bool        addr_legal,
    output atom_cfg_t  new_cfg
);

    always_comb begin
        new_cfg    = cur_cfg;
        addr_legal = 1'b1;
        case (wr_addr)
            CFG_ADDR_CTRL: begin
                // Bits above the rel_opcode field have no home and are dropped
                new_cfg.sel_1      = wr_data[CTRL_SEL_1];
                new_cfg.sel_2      = wr_data[CTRL_SEL_2 +: 2];
                new_cfg.sel_3      = wr_data[CTRL_SEL_3];
                new_cfg.sel_4      = wr_data[CTRL_SEL_4 +: 2];
                new_cfg.sel_5      = wr_data[CTRL_SEL_5];
                new_cfg.sel_6      = wr_data[CTRL_SEL_6 +: 2];
                new_cfg.rel_opcode = wr_data[CTRL_REL_OP +: 2];
            end
            CFG_ADDR_CONS1: new_cfg.cons_1 = wr_data;
            CFG_ADDR_CONS2: new_cfg.cons_2 = wr_data;
            CFG_ADDR_CONS3: new_cfg.cons_3 = wr_data;
            default:        addr_legal     = 1'b0;
        endcase
    end

endmodule

// File: rtl/atom_cfg_loader.sv
// rtl/atom_cfg_loader.sv - shadow/active config banks for the if/else atom, committed on a bubble
module atom_cfg_loader
    import atomsyn_pkg::*;
#(
    parameter int MAX_WAIT = 256,
    parameter int GEN_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    atom_cfg_loader_if.slave   cfg,
    input  logic               pkt_valid,
    output logic               sel_1,
    output logic [1:0]         sel_2,
    output logic               sel_3,
    output logic [1:0]         sel_4,
    output logic               sel_5,
    output logic [1:0]         sel_6,
    output logic [1:0]         rel_opcode,
    output int32_t             cons_1,
    output int32_t             cons_2,
    output int32_t             cons_3
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GEN_W-1:0]  gen_q;
    atom_cfg_t         shadow_q, shadow_d, active_q;
    bool               addr_legal;
    logic              wr_ready, wr_fire;
    logic              commit_go, abort_go;
    logic              wr_err_q, ack_q, err_q;

    atom_cfg_decode u_decode (
        .wr_addr    (cfg.cfg_wr_addr),
        .wr_data    (cfg.cfg_wr_data),
        .cur_cfg    (shadow_q),
        .addr_legal (addr_legal),
        .new_cfg    (shadow_d)
    );

    // Writes are blocked while a commit is pending so the copied bank is stable
    assign wr_ready = rst_n && (state_q == IDLE);
    assign wr_fire  = cfg.cfg_wr_valid && wr_ready;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        commit_go = 1'b0;
        abort_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_commit_req) begin
                    state_d = PENDING;
                    wait_d  = '0;
                end
            end
            PENDING: begin
                if (!pkt_valid) begin
                    commit_go = 1'b1;
                    state_d   = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    abort_go = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            gen_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            wr_err_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            wr_err_q <= wr_fire && !addr_legal;
            ack_q    <= commit_go;
            err_q    <= abort_go;
            if (wr_fire && addr_legal) begin
                shadow_q <= shadow_d;
            end
            if (commit_go) begin
                active_q <= shadow_q;
                gen_q    <= gen_q + GEN_W'(1);
            end
        end
    end

    assign cfg.cfg_wr_ready   = wr_ready;
    assign cfg.cfg_wr_err     = wr_err_q;
    assign cfg.cfg_commit_ack = ack_q;
    assign cfg.cfg_commit_err = err_q;
    assign cfg.cfg_gen        = gen_q;

    assign sel_1      = active_q.sel_1;
    assign sel_2      = active_q.sel_2;
    assign sel_3      = active_q.sel_3;
    assign sel_4      = active_q.sel_4;
    assign sel_5      = active_q.sel_5;
    assign sel_6      = active_q.sel_6;
    assign rel_opcode = active_q.rel_opcode;
    assign cons_1     = active_q.cons_1;
    assign cons_2     = active_q.cons_2;
    assign cons_3     = active_q.cons_3;

endmodule

// File: tb/tb_atom_cfg_loader.sv
// tb/tb_atom_cfg_loader.sv - directed self-checking bench for atom_cfg_loader
module tb_atom_cfg_loader;

    logic clk;
    logic rst_n;
    logic pkt_valid_a, pkt_valid_b;
    logic [31:0] pkt_1;
    logic [31:0] atom_state;
    int checks;
    int errors;

    logic        sel1_a, sel3_a, sel5_a, sel1_b, sel3_b, sel5_b;
    logic [1:0]  sel2_a, sel4_a, sel6_a, rel_a, sel2_b, sel4_b, sel6_b, rel_b;
    logic [31:0] cons1_a, cons2_a, cons3_a, cons1_b, cons2_b, cons3_b;
    logic [10:0] ctrl_a, ctrl_b;

    atom_cfg_loader_if #(.GEN_W(8)) ifa ();
    atom_cfg_loader_if #(.GEN_W(8)) ifb ();

    atom_cfg_loader #(.MAX_WAIT(256), .GEN_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg(ifa), .pkt_valid(pkt_valid_a),
        .sel_1(sel1_a), .sel_2(sel2_a), .sel_3(sel3_a), .sel_4(sel4_a),
        .sel_5(sel5_a), .sel_6(sel6_a), .rel_opcode(rel_a),
        .cons_1(cons1_a), .cons_2(cons2_a), .cons_3(cons3_a)
    );

    atom_cfg_loader #(.MAX_WAIT(4), .GEN_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg(ifb), .pkt_valid(pkt_valid_b),
        .sel_1(sel1_b), .sel_2(sel2_b), .sel_3(sel3_b), .sel_4(sel4_b),
        .sel_5(sel5_b), .sel_6(sel6_b), .rel_opcode(rel_b),
        .cons_1(cons1_b), .cons_2(cons2_b), .cons_3(cons3_b)
    );

    assign ctrl_a = {rel_a, sel6_a, sel5_a, sel4_a, sel3_a, sel2_a, sel1_a};
    assign ctrl_b = {rel_b, sel6_b, sel5_b, sel4_b, sel3_b, sel2_b, sel1_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter atom downstream of dut_a: adds cons_1 when sel_1, else pkt_1
    always @(posedge clk) begin
        if (!rst_n) atom_state <= 32'd0;
        else if (pkt_valid_a) atom_state <= atom_state + (sel1_a ? cons1_a : pkt_1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
        ifa.cfg_wr_valid = 1'b1; ifa.cfg_wr_addr = a; ifa.cfg_wr_data = d;
        step();
        ifa.cfg_wr_valid = 1'b0;
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
        ifb.cfg_wr_valid = 1'b1; ifb.cfg_wr_addr = a; ifb.cfg_wr_data = d;
        step();
        ifb.cfg_wr_valid = 1'b0;
    endtask

    // Request in IDLE, then one bubble cycle; returns in the ack cycle
    task automatic commit_a();
        ifa.cfg_commit_req = 1'b1;
        step();
        ifa.cfg_commit_req = 1'b0;
        step();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; pkt_valid_a = 1'b0; pkt_valid_b = 1'b0; pkt_1 = 32'd0;
        ifa.cfg_wr_valid = 1'b0; ifa.cfg_wr_addr = 3'd0; ifa.cfg_wr_data = 32'd0; ifa.cfg_commit_req = 1'b0;
        ifb.cfg_wr_valid = 1'b0; ifb.cfg_wr_addr = 3'd0; ifb.cfg_wr_data = 32'd0; ifb.cfg_commit_req = 1'b0;
        step(); step();

        chk("rst_ready", ifa.cfg_wr_ready, 1'b0);
        chk("rst_ctrl", ctrl_a, 11'h000);
        chk("rst_cons", {cons1_a, cons3_a}, 64'd0);
        chk("rst_gen", ifa.cfg_gen, 8'h00);
        chk("rst_b_ctrl", ctrl_b, 11'h000);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", ifa.cfg_wr_ready, 1'b1);

        // Full ctrl word plus constants, committed on an immediate bubble
        wr_a(3'd0, 32'h0000_07FF);
        wr_a(3'd1, 32'd5);
        wr_a(3'd2, 32'd6);
        wr_a(3'd3, 32'd7);
        chk("pre_commit_ctrl", ctrl_a, 11'h000);
        ifa.cfg_commit_req = 1'b1;
        step();
        ifa.cfg_commit_req = 1'b0;
        chk("pend_ready", ifa.cfg_wr_ready, 1'b0);
        chk("pend_noack", ifa.cfg_commit_ack, 1'b0);
        chk("pend_ctrl_old", ctrl_a, 11'h000);
        step();
        chk("c1_ack", ifa.cfg_commit_ack, 1'b1);
        chk("c1_ctrl", ctrl_a, 11'h7FF);
        chk("c1_cons", {32'd0, cons1_a} + {cons2_a, cons3_a}, {32'd6, 32'd12});
        chk("c1_gen", ifa.cfg_gen, 8'd1);
        step();
        chk("c1_ack_drop", ifa.cfg_commit_ack, 1'b0);

        // Upper ctrl bits ignored; commit stalled by 10 packet cycles
        wr_a(3'd0, 32'hFFFF_F923);
        wr_a(3'd1, 32'hDEAD_BEEF);
        pkt_valid_a = 1'b1;
        ifa.cfg_commit_req = 1'b1;
        step();
        ifa.cfg_commit_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_ready", ifa.cfg_wr_ready, 1'b0);
            chk("stall_ack", ifa.cfg_commit_ack, 1'b0);
            chk("stall_hold", {21'd0, ctrl_a, cons1_a}, {21'd0, 11'h7FF, 32'd5});
            step();
        end
        pkt_valid_a = 1'b0;
        chk("bubble_ready", ifa.cfg_wr_ready, 1'b0);
        step();
        chk("c2_ack", ifa.cfg_commit_ack, 1'b1);
        chk("c2_ctrl", ctrl_a, 11'h123);
        chk("c2_cons1", cons1_a, 32'hDEAD_BEEF);
        chk("c2_gen", ifa.cfg_gen, 8'd2);
        step();

        // Illegal address: error pulse, shadow untouched, re-commit re-applies
        wr_a(3'd5, 32'h1234_5678);
        chk("ill_err", ifa.cfg_wr_err, 1'b1);
        step();
        chk("ill_err_drop", ifa.cfg_wr_err, 1'b0);
        commit_a();
        chk("c3_ack", ifa.cfg_commit_ack, 1'b1);
        chk("c3_same", {21'd0, ctrl_a, cons1_a}, {21'd0, 11'h123, 32'hDEAD_BEEF});
        chk("c3_cons3", cons3_a, 32'd7);
        chk("c3_gen", ifa.cfg_gen, 8'd3);
        step();

        // Write accepted in the same cycle as the commit request
        ifa.cfg_wr_valid = 1'b1; ifa.cfg_wr_addr = 3'd2; ifa.cfg_wr_data = 32'h0000_CAFE;
        ifa.cfg_commit_req = 1'b1;
        step();
        ifa.cfg_wr_valid = 1'b0; ifa.cfg_commit_req = 1'b0;
        step();
        chk("c4_ack", ifa.cfg_commit_ack, 1'b1);
        chk("c4_cons2", cons2_a, 32'h0000_CAFE);
        chk("c4_gen", ifa.cfg_gen, 8'd4);
        step();

        // Reset while PENDING drops the commit
        pkt_valid_a = 1'b1;
        ifa.cfg_commit_req = 1'b1;
        step();
        ifa.cfg_commit_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", ctrl_a, 11'h000);
        chk("mid_rst_cons", {cons1_a, cons2_a}, 64'd0);
        chk("mid_rst_gen", ifa.cfg_gen, 8'h00);
        chk("mid_rst_ready", ifa.cfg_wr_ready, 1'b0);
        step(); step();
        rst_n = 1'b1;
        pkt_valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_quiet", {ifa.cfg_commit_ack, ifa.cfg_commit_err, ifa.cfg_wr_ready}, 3'b001);
        end
        chk("post_rst_ctrl", ctrl_a, 11'h000);

        // Generation counter wraps after 256 commits
        for (int i = 1; i <= 256; i++) begin
            commit_a();
            if (i == 255) chk("gen_ff", ifa.cfg_gen, 8'hFF);
        end
        chk("gen_wrap", ifa.cfg_gen, 8'h00);
        chk("gen_wrap_ack", ifa.cfg_commit_ack, 1'b1);
        step();

        // Counter atom end to end: pkt_1 increments, then cons_1 increments
        pkt_valid_a = 1'b1;
        pkt_1 = 32'd3; step();
        pkt_1 = 32'd4; step();
        pkt_1 = 32'd5; step();
        pkt_valid_a = 1'b0;
        chk("atom_pkt_sum", atom_state, 32'd12);
        wr_a(3'd0, 32'h0000_0001);
        wr_a(3'd1, 32'd10);
        commit_a();
        pkt_valid_a = 1'b1; pkt_1 = 32'd99;
        step(); step();
        pkt_valid_a = 1'b0;
        chk("atom_cons_sum", atom_state, 32'd32);

        // MAX_WAIT=4 instance: abort, then successful re-commit
        wr_b(3'd0, 32'h0000_0055);
        wr_b(3'd1, 32'd9);
        ifb.cfg_commit_req = 1'b1; step(); ifb.cfg_commit_req = 1'b0; step();
        chk("b1_ack", ifb.cfg_commit_ack, 1'b1);
        chk("b1_ctrl", ctrl_b, 11'h055);
        step();
        wr_b(3'd0, 32'h0000_02AA);
        pkt_valid_b = 1'b1;
        ifb.cfg_commit_req = 1'b1;
        step();
        ifb.cfg_commit_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b_wait_err", ifb.cfg_commit_err, 1'b0);
            chk("b_wait_ready", ifb.cfg_wr_ready, 1'b0);
            step();
        end
        chk("b_abort_err", ifb.cfg_commit_err, 1'b1);
        chk("b_abort_ack", ifb.cfg_commit_ack, 1'b0);
        chk("b_abort_ctrl", ctrl_b, 11'h055);
        chk("b_abort_gen", ifb.cfg_gen, 8'd1);
        chk("b_abort_idle", ifb.cfg_wr_ready, 1'b1);
        step();
        chk("b_err_once", ifb.cfg_commit_err, 1'b0);
        pkt_valid_b = 1'b0;
        ifb.cfg_commit_req = 1'b1; step(); ifb.cfg_commit_req = 1'b0; step();
        chk("b2_ack", ifb.cfg_commit_ack, 1'b1);
        chk("b2_ctrl", ctrl_b, 11'h2AA);
        chk("b2_cons1", cons1_b, 32'd9);
        chk("b2_gen", ifb.cfg_gen, 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
